// File: rtl/clk_div_ctrl.sv
// Divisor-change sequencer for the shared clock divider: round-robin grant,
// gate the divided clock at a low phase, apply the divisor, settle, acknowledge.
module clk_div_ctrl #(
    parameter int NREQ     = 4,
    parameter int DIV_W    = 8,
    parameter int DIV_RST  = 2,
    parameter int WAIT_MAX = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*DIV_W-1:0] req_div_i,
    input  logic                  clk_div_in_i,
    output logic [DIV_W-1:0]      div_out_o,
    output logic                  gate_en_o,
    output logic                  busy_o,
    output logic [NREQ-1:0]       ack_o,
    output logic                  err_o
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int CNT_W  = DIV_W + 1;

    typedef enum logic [2:0] {IDLE, WAIT_LOW, APPLY, SETTLE, DONE} state_e;

    state_e                          state_q, state_d;
    logic [1:0]                      sync_q;
    logic [IDX_W-1:0]                idx_q, idx_d, rr_ptr_q, rr_ptr_d;
    logic [DIV_W-1:0]                d_q, d_d, div_q, div_d;
    logic                            err_flag_q, err_flag_d, gate_q, gate_d;
    logic [WCNT_W-1:0]               wcnt_q, wcnt_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    logic [NREQ-1:0][DIV_W-1:0]      req_div_a;
    logic                            clk_sync;
    logic                            gnt_vld;
    logic [IDX_W-1:0]                gnt_idx;
    int                              cand;

    assign req_div_a = req_div_i;
    assign clk_sync  = sync_q[1];

    // Rotating priority: first requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NREQ;
            if (!gnt_vld && req_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        d_d        = d_q;
        err_flag_d = err_flag_q;
        rr_ptr_d   = rr_ptr_q;
        wcnt_d     = wcnt_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        gate_d     = gate_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    idx_d = gnt_idx;
                    d_d   = req_div_a[gnt_idx];
                    if (req_div_a[gnt_idx] < DIV_W'(2)) begin
                        err_flag_d = 1'b1;
                        state_d    = DONE;
                    end else if (req_div_a[gnt_idx] == div_q) begin
                        state_d = DONE;
                    end else begin
                        wcnt_d  = '0;
                        state_d = WAIT_LOW;
                    end
                end
            end
            WAIT_LOW: begin
                // Give up waiting for a low phase after WAIT_MAX cycles.
                if (!clk_sync || wcnt_q == WCNT_W'(WAIT_MAX)) begin
                    gate_d  = 1'b0;
                    state_d = APPLY;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            APPLY: begin
                div_d   = d_q;
                cnt_d   = {d_q, 1'b0} - CNT_W'(1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    gate_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                rr_ptr_d   = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
                err_flag_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            state_q    <= IDLE;
            idx_q      <= '0;
            d_q        <= '0;
            err_flag_q <= 1'b0;
            rr_ptr_q   <= '0;
            wcnt_q     <= '0;
            cnt_q      <= '0;
            div_q      <= DIV_W'(DIV_RST);
            gate_q     <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], clk_div_in_i};
            state_q    <= state_d;
            idx_q      <= idx_d;
            d_q        <= d_d;
            err_flag_q <= err_flag_d;
            rr_ptr_q   <= rr_ptr_d;
            wcnt_q     <= wcnt_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            gate_q     <= gate_d;
        end
    end

    // Completion outputs come straight from registered state.
    always_comb begin
        ack_o = '0;
        if (state_q == DONE) ack_o[idx_q] = 1'b1;
    end

    assign err_o     = (state_q == DONE) && err_flag_q;
    assign busy_o    = (state_q != IDLE);
    assign div_out_o = div_q;
    assign gate_en_o = gate_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a batch-level model predicts grant order,
// outcome and busy/gate-low durations; a monitor checks each ack against it.
module tb_clk_div_ctrl;
    localparam int NREQ     = 4;
    localparam int DIV_W    = 8;
    localparam int DIV_RST  = 2;
    localparam int WAIT_MAX = 15;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*DIV_W-1:0] req_div;
    logic                  clk_div_in;
    logic [DIV_W-1:0]      div_out;
    logic                  gate_en, busy, err;
    logic [NREQ-1:0]       ack;

    clk_div_ctrl #(.NREQ(NREQ), .DIV_W(DIV_W), .DIV_RST(DIV_RST), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_div_i(req_div),
        .clk_div_in_i(clk_div_in), .div_out_o(div_out), .gate_en_o(gate_en),
        .busy_o(busy), .ack_o(ack), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int err;
        int div;
        int bcyc;
        int gcyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state and per-batch stimulus description
    int         cur_div;
    int         ptr;
    logic [7:0] m_div [NREQ];
    bit         rr_v  [NREQ];
    logic [7:0] rr_d  [NREQ];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Serve a pending set to completion: rotating priority, each request
    // consumed once unless it is re-raised with a new divisor after its ack.
    task automatic predict(input logic [NREQ-1:0] mask, input bit lvl);
        logic [NREQ-1:0] p;
        int dv[NREQ];
        bit rv[NREQ];
        int rd[NREQ];
        int j, d, w;
        exp_t e;
        p = mask;
        for (int i = 0; i < NREQ; i++) begin
            dv[i] = int'(m_div[i]); rv[i] = rr_v[i]; rd[i] = int'(rr_d[i]);
        end
        w = lvl ? WAIT_MAX + 1 : 1;
        while (p != 0) begin
            j = -1;
            for (int k = 0; k < NREQ; k++)
                if (j < 0 && p[(ptr + k) % NREQ]) j = (ptr + k) % NREQ;
            d = dv[j];
            e.idx = j;
            e.err = (d < 2) ? 1 : 0;
            if (d < 2 || d == cur_div) begin
                e.bcyc = 1;
                e.gcyc = 0;
            end else begin
                e.bcyc = w + 2 * d + 2;
                e.gcyc = 2 * d + 1;
                cur_div = d;
            end
            e.div = cur_div;
            exp_q.push_back(e);
            ptr = (j + 1) % NREQ;
            if (rv[j]) begin dv[j] = rd[j]; rv[j] = 1'b0; end
            else p[j] = 1'b0;
        end
    endtask

    // Requester behaviour: drop (or re-arm) on ack; return once everything drains.
    task automatic drain();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    if (rr_v[i]) begin
                        req_div[i*DIV_W +: DIV_W] = rr_d[i];
                        rr_v[i] = 1'b0;
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            if (exp_q.size() == 0 && !busy && req == '0) break;
            n++;
            if (n > 5000) begin
                n_checks++; n_fail++;
                $display("FAIL drain_timeout: %0d acks outstanding, busy=%0d", exp_q.size(), busy);
                exp_q.delete();
                req = '0;
                break;
            end
        end
    endtask

    task automatic launch(input logic [NREQ-1:0] mask, input bit lvl, input bit midop);
        clk_div_in = lvl;
        repeat (4) @(negedge clk);
        for (int i = 0; i < NREQ; i++) req_div[i*DIV_W +: DIV_W] = m_div[i];
        predict(mask, lvl);
        req = mask;
        if (midop) begin
            repeat (3) @(negedge clk);
            req_div[0 +: DIV_W] = ~m_div[0];
            req[0] = 1'b0;
        end
        drain();
    endtask

    // Monitor: cycle-accurate bookkeeping and comparison on every ack.
    initial begin
        int bc, gc;
        exp_t e;
        bc = 0; gc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bc = 0; gc = 0;
            end else begin
                if (busy) bc++;
                if (busy && !gate_en) gc++;
                if (!busy) chk("gate_idle", int'(gate_en), 1);
                if (ack == '0) begin
                    chk("err_without_ack", int'(err), 0);
                end else if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ack: ack=%b expected none", ack);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_vector", int'(ack), 1 << e.idx);
                    chk("err", int'(err), e.err);
                    chk("div_out", int'(div_out), e.div);
                    chk("gate_at_ack", int'(gate_en), 1);
                    chk("busy_cycles", bc, e.bcyc);
                    chk("gate_low_cycles", gc, e.gcyc);
                end
                if (ack != '0) begin bc = 0; gc = 0; end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] mask;
        rst_n = 1'b0; req = '0; req_div = '0; clk_div_in = 1'b0;
        for (int i = 0; i < NREQ; i++) begin m_div[i] = 8'd0; rr_v[i] = 1'b0; rr_d[i] = 8'd0; end
        cur_div = DIV_RST; ptr = 0;
        repeat (3) @(negedge clk);
        chk("rst_div_out", int'(div_out), DIV_RST);
        chk("rst_gate_en", int'(gate_en), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;

        // Single change, divider output low
        m_div[0] = 8'd4;
        launch(4'b0001, 1'b0, 1'b0);

        // All four requesters, requester 1 re-arms with a new divisor
        m_div[0] = 8'd5; m_div[1] = 8'd6; m_div[2] = 8'd7; m_div[3] = 8'd3;
        rr_v[1] = 1'b1; rr_d[1] = 8'd9;
        launch(4'b1111, 1'b0, 1'b0);

        // Rejected divisors
        m_div[2] = 8'd0;
        launch(4'b0100, 1'b0, 1'b0);
        m_div[3] = 8'd1;
        launch(4'b1000, 1'b0, 1'b0);

        // Same divisor: no gating
        m_div[1] = 8'(cur_div);
        launch(4'b0010, 1'b0, 1'b0);

        // Divider output stuck high: wait times out
        m_div[0] = 8'd11;
        launch(4'b0001, 1'b1, 1'b0);

        // Requester changes its divisor and drops req after grant
        m_div[0] = 8'd5;
        launch(4'b0001, 1'b0, 1'b1);

        // Reset during SETTLE
        clk_div_in = 1'b0;
        repeat (4) @(negedge clk);
        m_div[0] = 8'd6;
        req_div[0 +: DIV_W] = m_div[0];
        predict(4'b0001, 1'b0);
        req = 4'b0001;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_gate_en", int'(gate_en), 1);
        chk("midrst_div_out", int'(div_out), DIV_RST);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ack", int'(ack), 0);
        exp_q.delete();
        cur_div = DIV_RST; ptr = 0; req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_div[2] = 8'd7;
        launch(4'b0100, 1'b0, 1'b0);

        // Randomized batches
        for (int b = 0; b < 25; b++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                m_div[i] = ($urandom_range(0, 5) == 0) ? 8'(cur_div) : 8'($urandom_range(0, 12));
                rr_v[i]  = ($urandom_range(0, 4) == 0);
                rr_d[i]  = 8'($urandom_range(0, 12));
            end
            launch(mask, $urandom_range(0, 4) == 0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
